count_seg7_driver: RTL and testbench
====================================

Name: count_seg7_driver

Overview:
- Downstream consumer of the 4-bit counter value (0..15).
- Captures each new count over a valid/ready handshake and converts it to two decimal digits.
- Time-multiplexes the digits onto a 2-digit common-anode seven-segment display, with leading-zero blanking.
- Lights a "value changed" decimal point for a programmable number of scan frames after each new value.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range >= 1.
- HOLD_FRAMES, 8: number of full scan frames the change-dp stays lit; 0 disables the dp.
- ACTIVE_LOW, 1: 1 = seg, dp and an are active-low; 0 = active-high.

Ports:
- clk      in   1  single system clock, rising edge
- rst      in   1  synchronous, active-high reset
- cnt      in   4  counter value from the counter stage
- cnt_vld  in   1  cnt is valid this cycle
- cnt_rdy  out  1  block can accept cnt this cycle
- cur      out  4  last accepted count
- seg      out  7  segments; seg[0]=a .. seg[6]=g
- dp       out  1  decimal point
- an       out  2  digit enables; an[0]=ones, an[1]=tens

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values (while rst=1 and on the first edge after it):
  - cur=0, ones=0, tens=0, sel=0, prescaler=0, hold=0, capture FSM=IDLE, cnt_rdy=0.
  - seg, dp and an all at their inactive level. With ACTIVE_LOW=1 that is seg=7'h7F, dp=1, an=2'b11.
- Reset taken mid-operation abandons any in-progress conversion. No partial capture is retained.
- Capture FSM:
  - IDLE: cnt_rdy=1. On cnt_vld && cnt_rdy at edge N: cur<=cnt, go to CONV.
  - CONV: exactly 1 cycle, cnt_rdy=0. Registers tens = (cur>=10), ones = cur - 10*tens. Returns to IDLE.
  - cnt_rdy is registered; it deasserts the cycle after an accept.
  - cnt_vld while cnt_rdy=0 is ignored, not queued. Upstream must hold cnt/cnt_vld until accepted.
  - Maximum throughput is one value every 2 cycles.
- Change flag:
  - On accept with cnt != cur (old value): hold <= HOLD_FRAMES.
  - On accept with cnt == cur: hold is unchanged.
  - hold decrements, saturating at 0, at each frame end.
- Scan:
  - prescaler counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and sel toggles.
  - A frame is sel 0->1->0. Frame end is the edge where sel goes 1->0.
  - Prescaler and sel run freely, independent of the handshake.
- Outputs: registered every cycle from sel, ones, tens and hold.
  - sel=0: an[0] active, seg=enc(ones); dp active iff hold>0.
  - sel=1: an[1] active iff tens!=0, else both anodes inactive (leading-zero blank); seg=enc(tens); dp inactive.
- Latency:
  - Accept at edge N: cur visible after N; ones/tens after N+1; seg/an reflect the new digits after N+2, in the slot currently selected.
- Encoding, active-high a..g:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - ACTIVE_LOW=1 inverts seg, dp and an.
- Boundaries:
  - Counter wrap 15->0 is a change: dp re-arms, tens blanks.
  - Accept on the same edge as a frame end: the reload wins (hold=HOLD_FRAMES).
  - REFRESH_DIV=1: sel toggles every cycle.

Test Plan (REFRESH_DIV=4, HOLD_FRAMES=2, ACTIVE_LOW=1):
- Reset: rst=1 for 3 cycles -> seg=7F, dp=1, an=11, cnt_rdy=0. After release: cnt_rdy=1, cur=0; in the sel=0 slot seg=40, an=10; in the sel=1 slot an=11 (blanked).
- Back-to-back: cnt=4 with cnt_vld held from N; cnt changes to 8 at N+1 -> 4 accepted at N, cnt_rdy=0 in the following cycle, 8 accepted at N+2, cur=8.
- Two digits: accept 13 -> sel=1 slot: an=01, seg=79 ("1"); sel=0 slot: an=10, seg=30 ("3").
- dp hold: accept 5 from 13 -> dp=0 during sel=0 slots for 2 frames (16 cycles), then dp=1. Re-accept 5 -> dp stays 1.
- Wrap: accept 15 then 0 -> sel=1 slot an=11, sel=0 slot seg=40, dp re-armed for 2 frames.
- Reset mid-CONV: accept 9, assert rst the next cycle -> cur=0, ones=0, outputs inactive, cnt_rdy=0 until reset is released.

Source files
------------

// File: rtl/count_seg7_driver.sv
// count_seg7_driver: captures 4-bit counts over valid/ready and shows them
// as two multiplexed decimal digits with a timed "value changed" dp.
module count_seg7_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_FRAMES = 8,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt,
    input  logic       cnt_vld,
    output logic       cnt_rdy,
    output logic [3:0] cur,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t        state;
    logic [3:0]    ones;
    logic          tens;
    logic          sel;
    logic [PW-1:0] prescaler;
    logic [HW-1:0] hold;

    logic          accept;
    logic          frame_end;
    logic [3:0]    digit;
    logic [6:0]    seg_raw;
    logic [1:0]    an_raw;
    logic          dp_raw;

    // cnt_rdy is only ever high in IDLE, so this is the full handshake
    assign accept    = cnt_vld && cnt_rdy;
    assign frame_end = sel && (prescaler == PS_LAST);

    // Capture FSM: accept into cur, then split into decimal digits
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur     <= 4'd0;
            ones    <= 4'd0;
            tens    <= 1'b0;
            cnt_rdy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cur     <= cnt;
                        state   <= CONV;
                        cnt_rdy <= 1'b0;
                    end else begin
                        cnt_rdy <= 1'b1;
                    end
                end
                CONV: begin
                    tens    <= (cur >= 4'd10);
                    ones    <= (cur >= 4'd10) ? cur - 4'd10 : cur;
                    state   <= IDLE;
                    cnt_rdy <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    cnt_rdy <= 1'b0;
                end
            endcase
        end
    end

    // Free-running digit scan: sel flips every REFRESH_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            sel       <= 1'b0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            sel       <= ~sel;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Change-dp frame counter; a reload beats a same-edge decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (accept && (cnt != cur)) begin
            hold <= HOLD_INIT;
        end else if (frame_end && (hold != '0)) begin
            hold <= hold - HW'(1);
        end
    end

    // Digit select and seven-segment encoding for the current slot
    always_comb begin
        digit   = sel ? {3'b000, tens} : ones;
        an_raw  = sel ? {tens, 1'b0} : 2'b01;
        dp_raw  = !sel && (hold != '0);
        seg_raw = 7'h00;
        case (digit)
            4'd0:    seg_raw = 7'h3F;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5B;
            4'd3:    seg_raw = 7'h4F;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6D;
            4'd6:    seg_raw = 7'h7D;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h6F;
            default: seg_raw = 7'h00;
        endcase
    end

    // Registered pins with optional active-low polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
            an  <= {2{ACTIVE_LOW}};
        end else begin
            seg <= seg_raw ^ {7{ACTIVE_LOW}};
            dp  <= dp_raw ^ ACTIVE_LOW;
            an  <= an_raw ^ {2{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_count_seg7_driver.sv
// tb_count_seg7_driver: randomized scoreboard bench for count_seg7_driver
// with an edge-indexed reference model of the display.
module tb_count_seg7_driver;

    localparam int R = 4;
    localparam int H = 2;
    localparam logic [6:0] ENC [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt;
    logic       cnt_vld;
    logic       cnt_rdy;
    logic [3:0] cur;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;

    always #5 clk = ~clk;

    count_seg7_driver #(
        .REFRESH_DIV(R),
        .HOLD_FRAMES(H),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt),
        .cnt_vld(cnt_vld),
        .cnt_rdy(cnt_rdy),
        .cur    (cur),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    typedef struct {
        int edge_no;
        int val;
    } acc_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    acc_t hist[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // value the model holds after the given edge since reset
    function automatic int value_at(input int e);
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i].edge_no <= e) return hist[i].val;
        return 0;
    endfunction

    // Monitor: checks every cycle at the falling edge
    initial begin : monitor
        bit         rst_edge;
        bit         acc_edge;
        int         k;
        int         j;
        int         d;
        int         v;
        int         arm;
        bit         lit;
        logic [6:0] e_seg;
        logic [1:0] e_an;
        logic       e_dp;
        rst_edge = 1'b1;
        acc_edge = 1'b0;
        k        = 0;
        arm      = -1;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                k   = 0;
                arm = -1;
                hist.delete();
                exp_q.delete();
                chk("rst_seg", int'(seg), 'h7F);
                chk("rst_dp", int'(dp), 1);
                chk("rst_an", int'(an), 3);
                chk("rst_rdy", int'(cnt_rdy), 0);
                chk("rst_cur", int'(cur), 0);
            end else begin
                k++;
                j = k - 1;
                d = value_at(k - 2);
                lit = (arm >= 0) && ((j / (2 * R)) - (arm / (2 * R)) < H);
                if (((j / R) % 2) == 0) begin
                    e_seg = ~ENC[d % 10];
                    e_an  = 2'b10;
                    e_dp  = !lit;
                end else begin
                    e_seg = ~ENC[d / 10];
                    e_an  = (d >= 10) ? 2'b01 : 2'b11;
                    e_dp  = 1'b1;
                end
                chk("seg", int'(seg), int'(e_seg));
                chk("an", int'(an), int'(e_an));
                chk("dp", int'(dp), int'(e_dp));
                if (acc_edge) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_empty: accept seen, no expected value");
                        v = -1;
                    end else begin
                        v = exp_q.pop_front();
                    end
                    if (v != value_at(k - 1)) arm = k;
                    hist.push_back('{k, v});
                    chk("cur_accept", int'(cur), v);
                    chk("rdy_after_accept", int'(cnt_rdy), 0);
                end else begin
                    chk("cur", int'(cur), value_at(k));
                    chk("rdy", int'(cnt_rdy), 1);
                end
            end
            rst_edge = rst;
            acc_edge = cnt_vld && cnt_rdy && !rst;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one value and hold it until the handshake completes
    task automatic send(input int v);
        bit got;
        got     = 1'b0;
        cnt     = 4'(v);
        cnt_vld = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (cnt_rdy) begin
                got = 1'b1;
                exp_q.push_back(v);
            end
            @(posedge clk);
            #1;
        end
        cnt_vld = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: value %0d never accepted", v);
        end
    endtask

    task automatic pulse_rst(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    // Stimulus: directed scenarios followed by random traffic
    initial begin : stim
        int v;
        int last;
        int gap;
        rst     = 1'b1;
        cnt     = 4'd0;
        cnt_vld = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(10);

        send(4);
        send(8);
        tick(20);
        send(13);
        tick(20);
        send(5);
        tick(40);
        send(5);
        tick(30);
        send(15);
        tick(4);
        send(0);
        tick(40);
        send(9);
        pulse_rst(3);
        tick(10);

        last = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) v = last;
            else v = int'($urandom_range(0, 15));
            send(v);
            last = v;
            gap = int'($urandom_range(0, 12));
            if (gap > 0) tick(gap);
            if ($urandom_range(0, 49) == 0) begin
                pulse_rst(int'($urandom_range(1, 3)));
                last = 0;
            end
        end
        tick(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
